// File: rtl/rs_encoder_stream_if.sv
// Stream interface of the symbol-serial Reed-Solomon encoder.
// Handshake rule for both the input and the output channel: a symbol moves
// on a rising clock edge where valid && ready are both high; a source never
// makes valid depend on ready, and it holds data/flags steady while
// valid && !ready.
// The slave modport is the encoder's view; master is the view of the
// surrounding frame builder / scrambler pair.
interface rs_encoder_stream_if #(
    parameter int M = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_data;
    logic         out_parity;
    logic         out_last;
    logic         err_len;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_last, err_len
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_last, err_len
    );
endinterface

// File: rtl/rs_encoder_stream.sv
// Symbol-serial systematic Reed-Solomon encoder over GF(2^M).
// Message symbols pass through unchanged, then P parity symbols are appended
// from a registered LFSR holding the running remainder of m(x)*x^P mod g(x).
// Optional feature macro: RS_ENC_SHORTEN_EN (in_last ends a shortened
// message early; a full-length message without in_last pulses err_len).
module rs_encoder_stream #(
    parameter int             M         = 4,
    parameter int             K         = 13,
    parameter int             P         = 2,
    parameter logic [M:0]     PRIM_POLY = 5'b10011,
    parameter logic [P*M-1:0] GEN_POLY  = 8'h32
) (
    input  logic               clk,
    input  logic               rst,
    rs_encoder_stream_if.slave bus,
    output logic               o_dbg_state
);
    localparam int            CW         = $clog2(K + P + 1);
    localparam logic [CW-1:0] CNT_K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] CNT_P_LAST = CW'(P - 1);

    typedef enum logic {ST_MSG = 1'b0, ST_PARITY = 1'b1} state_t;

    // Shift-and-add multiply; with one constant operand it folds to XORs.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[M-1] ? ((sh << 1) ^ PRIM_POLY[M-1:0]) : (sh << 1);
        end
        return acc;
    endfunction

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [M-1:0]  r_lfsr      [P];
    logic [M-1:0]  w_lfsr_next [P];
    logic [M-1:0]  w_fb;
    logic          w_advance;
    logic          w_in_ready;
    logic          w_msg_end;

    logic          r_out_valid,  w_out_valid_next;
    logic [M-1:0]  r_out_data,   w_out_data_next;
    logic          r_out_parity, w_out_parity_next;
    logic          r_out_last,   w_out_last_next;
    logic          r_err_len,    w_err_next;

    // Next-state, LFSR update and output-register load for MSG/PARITY phases.
    always_comb begin
        w_advance         = !r_out_valid || bus.out_ready;
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_lfsr_next       = r_lfsr;
        w_in_ready        = 1'b0;
        w_msg_end         = 1'b0;
        w_err_next        = 1'b0;
        w_fb              = bus.in_data ^ r_lfsr[P-1];
        w_out_valid_next  = r_out_valid;
        w_out_data_next   = r_out_data;
        w_out_parity_next = r_out_parity;
        w_out_last_next   = r_out_last;
        case (r_state)
            ST_MSG: begin
                w_in_ready = w_advance;
                if (w_advance) w_out_valid_next = 1'b0;
                if (w_advance && bus.in_valid) begin
                    w_out_valid_next  = 1'b1;
                    w_out_data_next   = bus.in_data;
                    w_out_parity_next = 1'b0;
                    w_out_last_next   = 1'b0;
                    w_lfsr_next[0]    = gf_mul(GEN_POLY[0 +: M], w_fb);
                    for (int j = 1; j < P; j++) begin
                        w_lfsr_next[j] = r_lfsr[j-1] ^ gf_mul(GEN_POLY[j*M +: M], w_fb);
                    end
`ifdef RS_ENC_SHORTEN_EN
                    w_msg_end  = bus.in_last || (r_cnt == CNT_K_LAST);
                    w_err_next = !bus.in_last && (r_cnt == CNT_K_LAST);
`else
                    w_msg_end  = (r_cnt == CNT_K_LAST);
`endif
                    if (w_msg_end) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_PARITY;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_advance) begin
                    w_out_valid_next  = 1'b1;
                    w_out_data_next   = r_lfsr[P-1];
                    w_out_parity_next = 1'b1;
                    w_out_last_next   = (r_cnt == CNT_P_LAST);
                    w_lfsr_next[0]    = '0;
                    for (int j = 1; j < P; j++) begin
                        w_lfsr_next[j] = r_lfsr[j-1];
                    end
                    if (r_cnt == CNT_P_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_MSG;
                        for (int j = 0; j < P; j++) w_lfsr_next[j] = '0;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_MSG;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_MSG;
        else     r_state <= w_state_next;
    end

    // Counter, LFSR and output register; reset discards any partial codeword.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_parity <= 1'b0;
            r_out_last   <= 1'b0;
            r_err_len    <= 1'b0;
            for (int j = 0; j < P; j++) r_lfsr[j] <= '0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_out_valid  <= w_out_valid_next;
            r_out_data   <= w_out_data_next;
            r_out_parity <= w_out_parity_next;
            r_out_last   <= w_out_last_next;
            r_err_len    <= w_err_next;
            for (int j = 0; j < P; j++) r_lfsr[j] <= w_lfsr_next[j];
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_parity = r_out_parity;
    assign bus.out_last   = r_out_last;
    assign bus.err_len    = r_err_len;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_rs_encoder_stream.sv
// Bench for rs_encoder_stream: polynomial long-division reference model,
// scoreboard queue, per-cycle compare process and codeword syndrome checks.
`timescale 1ns/1ps
module tb_rs_encoder_stream;
  localparam int M = 4;
  localparam int K = 13;
  localparam int P = 2;
  localparam int N = 15;
  localparam int W = M + 2;
  localparam logic [M:0] PRIM = 5'b10011;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  bit   stall_en;
  bit   timed_out;
  int   checks;
  int   failures;
  int   exp_err;
  int   err_seen;
  int   exp_cw;
  int   cw_seen;
  time  msg_start_time;
  time  last_out_time;

  logic [M-1:0] gf_exp [0:N-1];
  int           gf_log [0:(1<<M)-1];
  logic [M-1:0] g_full [0:P];

  logic [W-1:0] exp_q[$];
  logic [M-1:0] rx[$];

  rs_encoder_stream_if #(.M(M)) bus();

  rs_encoder_stream #(.M(M), .K(K), .P(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // downstream ready: always 1, or a coin flip per cycle while stalling
  always begin
    @(posedge clk);
    #1;
    bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // GF(16) multiply through log/antilog tables
  function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
    if (a == '0 || b == '0) return '0;
    return gf_exp[(gf_log[a] + gf_log[b]) % N];
  endfunction

  // Horner evaluation of a codeword (highest degree first) at point a
  function automatic logic [M-1:0] eval_at(input logic [M-1:0] cw[$], input logic [M-1:0] a);
    logic [M-1:0] s;
    s = '0;
    foreach (cw[i]) s = gmul(s, a) ^ cw[i];
    return s;
  endfunction

  // parity = remainder of msg(x)*x^P divided by g(x), by schoolbook long division
  task automatic model_parity(input logic [M-1:0] msg[$], output logic [M-1:0] par[P]);
    logic [M-1:0] w[$];
    logic [M-1:0] c;
    w = msg;
    for (int k = 0; k < P; k++) w.push_back('0);
    for (int i = 0; i < msg.size(); i++) begin
      c = w[i];
      for (int k = 1; k <= P; k++) w[i+k] = w[i+k] ^ gmul(c, g_full[k]);
    end
    for (int k = 0; k < P; k++) par[k] = w[msg.size() + k];
  endtask

  task automatic send_sym(input logic [M-1:0] d, input logic l);
    int waited;
    if (timed_out) return;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout got=no_ready exp=ready at %0t", $time);
        timed_out = 1'b1;
        break;
      end
    end
    if (!timed_out) exp_q.push_back({1'b0, 1'b0, d});
    if (!timed_out && bus.in_ready) msg_start_time = (msg_start_time == 0) ? $time : msg_start_time;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input logic [M-1:0] msg[$], input bit use_last);
    logic [M-1:0] par[P];
    logic lb;
    model_parity(msg, par);
    for (int i = 0; i < msg.size(); i++) begin
      send_sym(msg[i], use_last && (i == msg.size() - 1));
    end
    if (timed_out) return;
    for (int k = 0; k < P; k++) begin
      lb = (k == P - 1);
      exp_q.push_back({lb, 1'b1, par[k]});
    end
    exp_cw++;
`ifdef RS_ENC_SHORTEN_EN
    if (!use_last) exp_err++;
`endif
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // compare process: every output transfer against the scoreboard
  logic [W-1:0] cur_w;
  logic [W-1:0] prev_w;
  logic [W-1:0] exp_w;
  bit           prev_stall;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      rx.delete();
    end else begin
      cur_w = {bus.out_last, bus.out_parity, bus.out_data};
      if (prev_stall) check("stall_hold", 32'({bus.out_valid, cur_w}), 32'({1'b1, prev_w}));
`ifndef RS_ENC_SHORTEN_EN
      check("err_len_idle", 32'(bus.err_len), 32'd0);
`endif
      if (bus.err_len) err_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output got=%0h exp=none at %0t", cur_w, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check("out_word", 32'(cur_w), 32'(exp_w));
        end
        rx.push_back(bus.out_data);
        if (bus.out_last) begin
          last_out_time = $time;
          cw_seen++;
`ifndef RS_ENC_SHORTEN_EN
          check("cw_len", 32'(rx.size()), 32'(K + P));
`endif
          check("syndrome_a0", 32'(eval_at(rx, 4'd1)), 32'd0);
          check("syndrome_a1", 32'(eval_at(rx, 4'd2)), 32'd0);
          rx.delete();
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_w     = cur_w;
    end
  end

  logic [M-1:0] mq[$];
  logic [M-1:0] mpar[P];
  logic [M:0]   v;

  initial begin
    checks = 0; failures = 0; exp_err = 0; err_seen = 0; exp_cw = 0; cw_seen = 0;
    timed_out = 1'b0; stall_en = 1'b0; msg_start_time = 0; last_out_time = 0;
    g_full[0] = 4'd1; g_full[1] = 4'd3; g_full[2] = 4'd2;   // g(x) = x^2 + 3x + 2
    v = 1;
    for (int i = 0; i < N; i++) begin
      gf_exp[i] = v[M-1:0];
      gf_log[v[M-1:0]] = i;
      v = v << 1;
      if (v[M]) v = v ^ PRIM;
    end
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_parity", 32'(bus.out_parity), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_err_len", 32'(bus.err_len), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // pin the model with hand-computed values
    check("gmul_2x2", 32'(gmul(4'd2, 4'd2)), 32'd4);
    check("gmul_8x2", 32'(gmul(4'd8, 4'd2)), 32'd3);
    mq.delete(); repeat (K - 1) mq.push_back('0); mq.push_back(4'd1);
    model_parity(mq, mpar);
    check("model_par0", 32'(mpar[0]), 32'd3);
    check("model_par1", 32'(mpar[1]), 32'd2);
    mq.delete(); repeat (K) mq.push_back('0);
    model_parity(mq, mpar);
    check("model_zero_par", 32'({mpar[0], mpar[1]}), 32'd0);

    // all-zero message, latency to out_last
    msg_start_time = 0;
    send_msg(mq, 1'b0);
    wait_drain();
    check("last_cycle", 32'((last_out_time - msg_start_time) / 10), 32'd15);

    // twelve zeros then 1 -> parity 3,2
    mq.delete(); repeat (K - 1) mq.push_back('0); mq.push_back(4'd1);
    send_msg(mq, 1'b0);
    wait_drain();

    // 500 random messages back-to-back
    for (int n = 0; n < 500; n++) begin
      mq.delete();
      for (int i = 0; i < K; i++) mq.push_back(4'($urandom_range(0, 15)));
      send_msg(mq, 1'b0);
    end
    wait_drain();

    // random back-pressure on the output
    stall_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      mq.delete();
      for (int i = 0; i < K; i++) mq.push_back(4'($urandom_range(0, 15)));
      send_msg(mq, 1'b0);
    end
    stall_en = 1'b0;
    wait_drain();

    // abort after 6 symbols, then a fresh 0..0,1 message
    for (int i = 0; i < 6; i++) send_sym(4'($urandom_range(1, 15)), 1'b0);
    wait_drain();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); repeat (K - 1) mq.push_back('0); mq.push_back(4'd1);
    send_msg(mq, 1'b1);
    wait_drain();

`ifdef RS_ENC_SHORTEN_EN
    // shortened message {0,0,1} -> parity 3,2
    mq.delete(); mq.push_back('0); mq.push_back('0); mq.push_back(4'd1);
    model_parity(mq, mpar);
    check("short_par", 32'({mpar[0], mpar[1]}), 32'h32);
    send_msg(mq, 1'b1);
    // single-symbol message
    mq.delete(); mq.push_back(4'($urandom_range(0, 15)));
    send_msg(mq, 1'b1);
    // full length without in_last
    mq.delete();
    for (int i = 0; i < K; i++) mq.push_back(4'($urandom_range(0, 15)));
    send_msg(mq, 1'b0);
    wait_drain();
`endif

    repeat (4) @(negedge clk);
    check("err_len_count", 32'(err_seen), 32'(exp_err));
    check("codeword_count", 32'(cw_seen), 32'(exp_cw));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_encoder_stream.md
Name: rs_encoder_stream

Overview:
- Symbol-serial, systematic Reed-Solomon encoder over GF(2^M). Parametrised in symbol width, parity count, message length and generator polynomial.
- Streaming successor to the fixed N15K13 parallel encoder, for links that move one symbol per clock instead of a full frame.
- Sits between the frame builder and the scrambler/serialiser.
- Accepts message symbols through a valid/ready handshake, passes them through unchanged, then appends P parity symbols computed by a registered LFSR.

Parameters:
- M, 4: symbol width in bits. GF(2^M). Legal range 3..8.
- K, 13: message symbols per codeword. Legal range 1..(2^M-1-P).
- P, 2: parity symbols per codeword. Legal range 1..8.
- PRIM_POLY, 5'b10011: field primitive polynomial, M+1 bits (x^4+x+1).
- GEN_POLY, 8'h32: generator coefficients g0..g(P-1), packed P*M bits, g0 in LSBs. The monic x^P term is implicit. Default is g(x)=x^2+3x+2.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: message symbol valid.
- in_ready, out, 1: encoder accepts a symbol this cycle.
- in_data, in, M: message symbol. The first accepted symbol is the highest-degree coefficient.
- in_last, in, 1: last message symbol. Used only with RS_ENC_SHORTEN_EN.
- out_valid, out, 1: output symbol valid.
- out_ready, in, 1: downstream accepts.
- out_data, out, M: message symbol or parity symbol.
- out_parity, out, 1: out_data is a parity symbol.
- out_last, out, 1: final parity symbol of the codeword.
- err_len, out, 1: one-cycle pulse on a length violation.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_parity=0, out_last=0, err_len=0, all LFSR registers=0, symbol counter=0, state=MSG.
- Reset asserted mid-codeword: the partial codeword is discarded and no parity is emitted.
- Output stage: a single register. It advances when (!out_valid || out_ready). It holds its value while out_valid && !out_ready.
- States:
  - MSG: in_ready = advance. On each accepted symbol:
    - fb = in_data XOR r[P-1]
    - r[j] = r[j-1] XOR g_j*fb for j=1..P-1
    - r[0] = g0*fb
    - output register loads in_data with out_parity=0
    - counter increments
    - when counter reaches K-1 on acceptance: counter clears and state goes to PARITY.
  - PARITY: in_ready=0. On each advance:
    - output loads r[P-1] with out_parity=1
    - LFSR shifts: r[j]=r[j-1], r[0]=0
    - counter increments
    - the P-th parity symbol sets out_last=1; counter and LFSR clear; state returns to MSG.
- GF multiply is combinational, fully parametrised by PRIM_POLY. Constant generator coefficients are legal and must synthesise to XOR networks.
- Latency: input symbol to out_data is 1 cycle.
- Throughput: K+P cycles per codeword, with no bubble between codewords when out_ready=1.
- Parity order: first emitted symbol equals the N15K13 encoder's parity[M-1:0] for the same 13-symbol message, with message symbol 0 fed first.
- Parity is always complete for K symbols; no partial parity is ever produced.
- Back-pressure in PARITY: the LFSR shifts only on advance.
- Without the optional feature: in_last is ignored and err_len stays 0.

Optional Feature:
- Macro: RS_ENC_SHORTEN_EN.
- Defined (shortened codewords):
  - in_last accepted in MSG ends the message early after K'<=K symbols and moves to PARITY. Parity is that of the shortened code, equivalent to leading zero padding.
  - Counter reaching K-1 without in_last is still treated as last and pulses err_len for one cycle.
  - in_last on the first symbol is legal (K'=1).
- Undefined: fixed length K; in_last unused; err_len tied to 0.

Test Plan:
- Reset, then 13 zero symbols with out_ready=1 -> 13 zero message outputs, then parity 0,0; out_last on cycle 15 after the first accept; no bubbles.
- Twelve zeros then symbol 1 -> outputs 0x0 x12, 0x1, then parity 3 then 2; out_parity=1 only on the last two outputs.
- 500 random 13-symbol messages, back-to-back -> every codeword matches a bit-exact N15K13 reference model, and every codeword syndrome at roots alpha^0 and alpha^1 is zero.
- out_ready toggled randomly (50%) during message and parity phases -> out_data is stable while stalled; no symbol dropped or duplicated; parity unchanged versus the no-stall run.
- rst pulsed after 6 accepted symbols, then a fresh all-zero-but-last=1 message -> no parity from the aborted frame; next parity is 3,2.
- With RS_ENC_SHORTEN_EN, send 3 symbols {0,0,1} with in_last on the third -> parity 3,2. With 13 symbols and no in_last -> err_len pulses once and parity is still emitted.
